// File: rtl/prng_pkg.sv
// prng_pkg: shared state encoding and active-high hex-to-7-segment table for the sample display
package prng_pkg;

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Active-high form; segment polarity is applied by the display stage
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] HEX_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] hex_seg(input logic [3:0] d);
      return HEX_TABLE[d];
   endfunction

endpackage

// File: rtl/prng_sample_display_if.sv
// prng_sample_display_if: random byte in, button in, held sample and 7-segment digits out
interface prng_sample_display_if;
   logic [7:0] rnd_in;
   logic       hold_btn;
   logic [7:0] sample_out;
   logic       sample_valid;
   logic       tick_out;
   logic [1:0] state_out;
   logic [6:0] HEX0;
   logic [6:0] HEX1;

   modport master (
      output rnd_in, hold_btn,
      input  sample_out, sample_valid, tick_out, state_out, HEX0, HEX1
   );

   modport slave (
      input  rnd_in, hold_btn,
      output sample_out, sample_valid, tick_out, state_out, HEX0, HEX1
   );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus stability counter; one-cycle pulse on accepted 0->1 level change
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 500_000
) (
   input  logic CLK,
   input  logic EN,
   input  logic btn_raw,
   output logic level,
   output logic press_pulse
);

   localparam int DW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYC - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_press;
   logic [DW-1:0] r_cnt;
   logic          w_accept;

   // Counter only advances while a level change is pending, so it never exceeds LAST
   assign w_accept = (r_s2 != r_level) && (r_cnt == LAST);

   always_ff @(posedge CLK or negedge EN) begin
      if (!EN) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= btn_raw;
         r_s2    <= r_s1;
         r_cnt   <= (r_s2 == r_level || w_accept) ? '0 : r_cnt + 1'b1;
         r_level <= w_accept ? r_s2 : r_level;
         r_press <= w_accept & r_s2;
      end
   end

   assign level       = r_level;
   assign press_pulse = r_press;

endmodule

// File: rtl/prng_sample_display.sv
// prng_sample_display: samples the PRNG byte once per update period, holds it, and drives two hex digits;
// a debounced button toggles freeze/resume.
module prng_sample_display
   import prng_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int UPDATE_HZ      = 1,
   parameter int DEBOUNCE_CYC   = 500_000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  CLK,
   input  logic                  EN,
   prng_sample_display_if.slave  bus
);

   localparam int DIV = CLK_HZ / UPDATE_HZ;
   localparam int W   = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   localparam logic [W-1:0] HALF = W'(DIV / 2);
   localparam logic [6:0] BLANK_OUT = SEG_ACTIVE_LOW != 0 ? ~SEG_BLANK : SEG_BLANK;

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_cnt_nxt;
   logic         w_tick;
   logic         w_level;
   logic         w_press_pulse;
   logic         w_press;
   logic         r_tick_out;
   state_t       r_state;
   logic [7:0]   r_sample;
   logic         r_valid;
   logic [6:0]   r_hex0;
   logic [6:0]   r_hex1;

   function automatic logic [6:0] pol(input logic [6:0] s);
      return SEG_ACTIVE_LOW != 0 ? ~s : s;
   endfunction

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .CLK         (CLK),
      .EN          (EN),
      .btn_raw     (bus.hold_btn),
      .level       (w_level),
      .press_pulse (w_press_pulse)
   );

   assign w_press   = w_press_pulse & w_level;
   assign w_tick    = r_cnt == LAST;
   assign w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;

   // tick_out is derived from the next count so it is high exactly while count >= DIV/2
   always_ff @(posedge CLK or negedge EN) begin
      if (!EN) begin
         r_cnt      <= '0;
         r_tick_out <= 1'b0;
         r_state    <= ST_BLANK;
         r_sample   <= '0;
         r_valid    <= 1'b0;
         r_hex0     <= BLANK_OUT;
         r_hex1     <= BLANK_OUT;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_tick_out <= w_cnt_nxt >= HALF;
         r_valid    <= 1'b0;
         r_hex0     <= r_state == ST_BLANK ? BLANK_OUT : pol(hex_seg(r_sample[3:0]));
         r_hex1     <= r_state == ST_BLANK ? BLANK_OUT : pol(hex_seg(r_sample[7:4]));
         case (r_state)
            ST_BLANK: begin
               if (w_tick) begin
                  r_sample <= bus.rnd_in;
                  r_valid  <= 1'b1;
                  r_state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_tick) begin
                  r_sample <= bus.rnd_in;
                  r_valid  <= 1'b1;
               end
               if (w_press) r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (w_press) r_state <= ST_RUN;
            end
            default: r_state <= ST_BLANK;
         endcase
      end
   end

   assign bus.sample_out   = r_sample;
   assign bus.sample_valid = r_valid;
   assign bus.tick_out     = r_tick_out;
   assign bus.state_out    = r_state;
   assign bus.HEX0         = r_hex0;
   assign bus.HEX1         = r_hex1;

endmodule
